// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one OBI-style data memory port between NUM_CORES core data interfaces.
// Requests are arbitrated round-robin, and responses are routed back in order
// using a FIFO of outstanding-transaction IDs. A per-core LR/SC reservation
// table decides whether each store-conditional succeeds.
//
// Ports (per-core vectors are flat; core i occupies slice i):
//   clk_i, nreset_i                     clock, asynchronous active-low reset
//   core_req_i/gnt_o                    per-core address-phase handshake
//   core_addr_i/be_i/we_i/wdata_i       per-core address phase
//   core_lr_sc_i                        atomic: LR when we=0, SC when we=1
//   core_rvalid_o                       per-core response valid
//   core_rdata_o/err_o/exokay_o         shared response payload, qualified by rvalid
//   mem_req_o/gnt_i, mem_addr_o/be_o/we_o/wdata_o   downstream address phase
//   mem_rvalid_i/rdata_i/err_i          downstream response phase
//   protocol_err_o                      sticky: response seen with nothing outstanding
module data_mem_arbiter #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic [NUM_CORES-1:0]    core_req_i,
    output logic [NUM_CORES-1:0]    core_gnt_o,
    input  logic [32*NUM_CORES-1:0] core_addr_i,
    input  logic [4*NUM_CORES-1:0]  core_be_i,
    input  logic [NUM_CORES-1:0]    core_we_i,
    input  logic [32*NUM_CORES-1:0] core_wdata_i,
    input  logic [NUM_CORES-1:0]    core_lr_sc_i,
    output logic [NUM_CORES-1:0]    core_rvalid_o,
    output logic [31:0]             core_rdata_o,
    output logic                    core_err_o,
    output logic                    core_exokay_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [31:0]             mem_addr_o,
    output logic [3:0]              mem_be_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_err_i,
    output logic                    protocol_err_o
);

    localparam int unsigned ID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned PTR_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);
    localparam int unsigned WADDR_W = 30;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_lr_sc;
        logic            sc_fail;
    } outst_t;

    state_t              state_q;
    logic [ID_W-1:0]     lock_q;
    logic [ID_W-1:0]     rr_q;

    outst_t              fifo_q [MAX_OUTST];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_CORES-1:0] resv_vld_q;
    logic [WADDR_W-1:0]   resv_addr_q [NUM_CORES];

    logic                protocol_err_q;

    logic                arb_found;
    logic [ID_W-1:0]     arb_sel;
    logic [ID_W-1:0]     sel;
    logic [ID_W-1:0]     next_rr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                req_c;
    logic                grant;
    logic                pop;
    logic [31:0]         sel_addr;
    logic [3:0]          sel_be;
    logic                sel_we;
    logic [31:0]         sel_wdata;
    logic                sel_is_lr;
    logic                sel_is_sc;
    logic                sc_match;
    logic                sc_fail;
    outst_t              head;

    // Round-robin pick: first requester at or after the rr pointer.
    always_comb begin
        int unsigned idx;
        arb_found = 1'b0;
        arb_sel   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = (32'(rr_q) + k) % NUM_CORES;
            if (!arb_found && core_req_i[idx]) begin
                arb_found = 1'b1;
                arb_sel   = ID_W'(idx);
            end
        end
    end

    // Address phase: selected core, SC check, downstream drive.
    always_comb begin
        fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
        fifo_empty = (cnt_q == '0);

        sel     = (state_q == ST_HOLD) ? lock_q : arb_sel;
        next_rr = ID_W'((32'(sel) + 32'd1) % NUM_CORES);

        // HOLD is only entered with room in the FIFO, so the held request never stalls on full.
        req_c = nreset_i & ((state_q == ST_HOLD) | (arb_found & ~fifo_full));

        sel_addr  = core_addr_i[32*int'(sel) +: 32];
        sel_be    = core_be_i[4*int'(sel) +: 4];
        sel_we    = core_we_i[sel];
        sel_wdata = core_wdata_i[32*int'(sel) +: 32];
        sel_is_lr = core_lr_sc_i[sel] & ~sel_we;
        sel_is_sc = core_lr_sc_i[sel] & sel_we;

        sc_match = resv_vld_q[sel] && (resv_addr_q[sel] == sel_addr[31:2]);
        sc_fail  = sel_is_sc & ~sc_match;

        mem_req_o   = req_c;
        mem_addr_o  = req_c ? sel_addr : '0;
        mem_we_o    = req_c & sel_we;
        mem_wdata_o = req_c ? sel_wdata : '0;
        // A failed SC still goes out to keep response ordering, but writes nothing.
        mem_be_o    = (req_c && !sc_fail) ? sel_be : 4'b0000;

        grant      = req_c & mem_gnt_i;
        core_gnt_o = '0;
        if (grant) begin
            core_gnt_o[sel] = 1'b1;
        end
    end

    // Response phase: route to the oldest outstanding transaction's owner.
    always_comb begin
        head          = fifo_q[rd_ptr_q];
        pop           = mem_rvalid_i & ~fifo_empty;
        core_rvalid_o = '0;
        if (pop) begin
            core_rvalid_o[head.id] = 1'b1;
        end
        core_rdata_o  = pop ? mem_rdata_i : '0;
        core_err_o    = pop & mem_err_i;
        core_exokay_o = pop & head.is_lr_sc & ~head.sc_fail & ~mem_err_i;
    end

    assign protocol_err_o = protocol_err_q;

    // Arbitration FSM: ARB picks a core each cycle; HOLD locks it until the downstream grant.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_ARB;
            lock_q  <= '0;
            rr_q    <= '0;
        end else begin
            if (grant) begin
                rr_q <= next_rr;
            end
            case (state_q)
                ST_ARB: begin
                    if (req_c && !mem_gnt_i) begin
                        state_q <= ST_HOLD;
                        lock_q  <= sel;
                    end
                end
                ST_HOLD: begin
                    if (mem_gnt_i) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Outstanding-transaction FIFO: push on grant, pop on response.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (grant) begin
                fifo_q[wr_ptr_q] <= '{id: sel, is_lr_sc: core_lr_sc_i[sel], sc_fail: sc_fail};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({grant, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Reservation table: LR sets own entry, SC clears own entry, any real write kills others on that word.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            resv_vld_q <= '0;
            for (int unsigned j = 0; j < NUM_CORES; j++) begin
                resv_addr_q[j] <= '0;
            end
        end else if (grant) begin
            for (int unsigned j = 0; j < NUM_CORES; j++) begin
                if (ID_W'(j) == sel) begin
                    if (sel_is_lr) begin
                        resv_vld_q[j]  <= 1'b1;
                        resv_addr_q[j] <= sel_addr[31:2];
                    end else if (sel_is_sc) begin
                        resv_vld_q[j] <= 1'b0;
                    end
                end else if (sel_we && !sc_fail && (resv_addr_q[j] == sel_addr[31:2])) begin
                    resv_vld_q[j] <= 1'b0;
                end
            end
        end
    end

    // Sticky flag for a downstream response with nothing outstanding.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            protocol_err_q <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            protocol_err_q <= 1'b1;
        end
    end

    // A core must keep its request up while its address phase is held.
    hold_req_kept: assert property (
        @(posedge clk_i) disable iff (!nreset_i)
        (state_q == ST_HOLD) |-> core_req_i[lock_q]
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: scoreboard of expected responses, pushed at
// grant time and popped when the memory model answers.
module tb_data_mem_arbiter;

    localparam int unsigned N = 2;

    logic            clk_i;
    logic            nreset_i;
    logic [N-1:0]    core_req_i;
    logic [N-1:0]    core_gnt_o;
    logic [32*N-1:0] core_addr_i;
    logic [4*N-1:0]  core_be_i;
    logic [N-1:0]    core_we_i;
    logic [32*N-1:0] core_wdata_i;
    logic [N-1:0]    core_lr_sc_i;
    logic [N-1:0]    core_rvalid_o;
    logic [31:0]     core_rdata_o;
    logic            core_err_o;
    logic            core_exokay_o;
    logic            mem_req_o;
    logic            mem_gnt_i;
    logic [31:0]     mem_addr_o;
    logic [3:0]      mem_be_o;
    logic            mem_we_o;
    logic [31:0]     mem_wdata_o;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic            mem_err_i;
    logic            protocol_err_o;

    typedef struct {
        int          core;
        logic [31:0] rdata;
        logic        exok;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] mq[$];
    int          chk_cnt = 0;
    int          err_cnt = 0;

    data_mem_arbiter #(.NUM_CORES(N), .MAX_OUTST(4)) dut (
        .clk_i          (clk_i),
        .nreset_i       (nreset_i),
        .core_req_i     (core_req_i),
        .core_gnt_o     (core_gnt_o),
        .core_addr_i    (core_addr_i),
        .core_be_i      (core_be_i),
        .core_we_i      (core_we_i),
        .core_wdata_i   (core_wdata_i),
        .core_lr_sc_i   (core_lr_sc_i),
        .core_rvalid_o  (core_rvalid_o),
        .core_rdata_o   (core_rdata_o),
        .core_err_o     (core_err_o),
        .core_exokay_o  (core_exokay_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .protocol_err_o (protocol_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_core(input int i, input logic req, input logic [31:0] addr,
                            input logic we, input logic lrsc, input logic [3:0] be);
        core_req_i[i]           = req;
        core_addr_i[i*32 +: 32] = addr;
        core_we_i[i]            = we;
        core_lr_sc_i[i]         = lrsc;
        core_be_i[i*4 +: 4]     = be;
        core_wdata_i[i*32 +: 32] = addr ^ 32'h5a5a_5a5a;
    endtask

    // Memory model answers the oldest accepted request with the inverted address.
    task automatic set_resp();
        if (mq.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ~mq.pop_front();
        end
    endtask

    // One cycle: sample at negedge, score responses, check address phase, advance.
    task automatic tick(input int gcore, input logic [31:0] addr, input logic exok,
                        input int exp_req, input int exp_be);
        resp_t e;
        logic [63:0] gexp;
        @(negedge clk_i);
        if (mem_rvalid_i) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_eq("rvalid", 64'(core_rvalid_o), 64'(1) << e.core);
                chk_eq("rdata", 64'(core_rdata_o), 64'(e.rdata));
                chk_eq("exokay", 64'(core_exokay_o), 64'(e.exok));
            end else begin
                chk_eq("rvalid_orphan", 64'(core_rvalid_o), 64'(0));
            end
        end
        if (exp_req >= 0) chk_eq("mem_req", 64'(mem_req_o), 64'(exp_req));
        if (exp_req == 1) chk_eq("mem_addr", 64'(mem_addr_o), 64'(addr));
        if (exp_be >= 0) chk_eq("mem_be", 64'(mem_be_o), 64'(exp_be));
        gexp = (gcore < 0) ? 64'(0) : (64'(1) << gcore);
        chk_eq("gnt", 64'(core_gnt_o), gexp);
        if (mem_req_o && mem_gnt_i) mq.push_back(mem_addr_o);
        if (gcore >= 0) begin
            e.core  = gcore;
            e.rdata = ~addr;
            e.exok  = exok;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
    endtask

    // Single transaction from one core, answered the following cycle.
    task automatic one_txn(input int c, input logic [31:0] addr, input logic we,
                           input logic lrsc, input logic exok, input int exp_be);
        set_core(c, 1'b1, addr, we, lrsc, 4'hf);
        tick(c, addr, exok, 1, exp_be);
        set_core(c, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_resp();
        tick(-1, 32'h0, 1'b0, 0, -1);
    endtask

    initial begin
        nreset_i     = 1'b0;
        core_req_i   = '0;
        core_addr_i  = '0;
        core_be_i    = '0;
        core_we_i    = '0;
        core_wdata_i = '0;
        core_lr_sc_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk_eq("rst_mem_req", 64'(mem_req_o), 64'(0));
        chk_eq("rst_gnt", 64'(core_gnt_o), 64'(0));
        chk_eq("rst_rvalid", 64'(core_rvalid_o), 64'(0));
        chk_eq("rst_proterr", 64'(protocol_err_o), 64'(0));
        @(posedge clk_i);
        #1;
        nreset_i = 1'b1;

        // Round robin with both cores requesting every cycle
        set_core(0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 4'hf);
        set_core(1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 4'hf);
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) set_resp();
            tick(i % 2, (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000, 1'b0, 1, -1);
        end
        set_core(0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_core(1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_resp();
        tick(-1, 32'h0, 1'b0, 0, -1);

        // HOLD: core 0 stalled 3 cycles, core 1 arrives (rr points at core 1)
        mem_gnt_i = 1'b0;
        set_core(0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 4'hf);
        tick(-1, 32'h0000_3000, 1'b0, 1, -1);
        set_core(1, 1'b1, 32'h0000_4000, 1'b0, 1'b0, 4'hf);
        tick(-1, 32'h0000_3000, 1'b0, 1, -1);
        tick(-1, 32'h0000_3000, 1'b0, 1, -1);
        mem_gnt_i = 1'b1;
        tick(0, 32'h0000_3000, 1'b0, 1, -1);
        set_core(0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_resp();
        tick(1, 32'h0000_4000, 1'b0, 1, -1);
        set_core(1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_resp();
        tick(-1, 32'h0, 1'b0, 0, -1);

        // FIFO full: 4 grants, request withheld, one response frees a slot
        set_core(0, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 4'hf);
        set_core(1, 1'b1, 32'h0000_6000, 1'b0, 1'b0, 4'hf);
        for (int i = 0; i < 4; i++) begin
            tick(i % 2, (i % 2 == 1) ? 32'h0000_6000 : 32'h0000_5000, 1'b0, 1, -1);
        end
        tick(-1, 32'h0, 1'b0, 0, -1);
        set_resp();
        tick(-1, 32'h0, 1'b0, 0, -1);
        tick(0, 32'h0000_5000, 1'b0, 1, -1);
        set_core(0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_core(1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            set_resp();
            tick(-1, 32'h0, 1'b0, 0, -1);
        end

        // LR/SC: reservation killed by another core's store, then a clean pair
        one_txn(0, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 15);
        one_txn(1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 15);
        one_txn(0, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 0);
        one_txn(0, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 15);
        one_txn(0, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 15);

        // Response with nothing outstanding
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hdead_beef;
        tick(-1, 32'h0, 1'b0, 0, -1);
        chk_eq("proterr_set", 64'(protocol_err_o), 64'(1));
        tick(-1, 32'h0, 1'b0, 0, -1);
        tick(-1, 32'h0, 1'b0, 0, -1);
        chk_eq("proterr_sticky", 64'(protocol_err_o), 64'(1));

        // Reset while core 1 is held; core 0 must win afterwards
        mem_gnt_i = 1'b0;
        set_core(1, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 4'hf);
        tick(-1, 32'h0000_7000, 1'b0, 1, -1);
        nreset_i = 1'b0;
        #1;
        chk_eq("mrst_mem_req", 64'(mem_req_o), 64'(0));
        chk_eq("mrst_mem_addr", 64'(mem_addr_o), 64'(0));
        chk_eq("mrst_gnt", 64'(core_gnt_o), 64'(0));
        chk_eq("mrst_proterr", 64'(protocol_err_o), 64'(0));
        repeat (2) @(posedge clk_i);
        #1;
        nreset_i = 1'b1;
        set_core(0, 1'b1, 32'h0000_7100, 1'b0, 1'b0, 4'hf);
        mem_gnt_i = 1'b1;
        tick(0, 32'h0000_7100, 1'b0, 1, -1);
        set_core(0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_core(1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_resp();
        tick(-1, 32'h0, 1'b0, 0, -1);
        chk_eq("proterr_clear", 64'(protocol_err_o), 64'(0));
        chk_eq("sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
